// File: rtl/impulse_count_receiver_pkg.sv
// rtl/impulse_count_receiver_pkg.sv - shared constants and state encoding for the counter link receiver
package impulse_link_pkg;

    localparam int CNT_W  = 16;
    localparam int N_CH   = 8;
    localparam int ADDR_W = 3;

    // Bit positions of the link lines on the bus handed to the synchronizer;
    // the two edge-detected lines sit at the bottom.
    localparam int LB_SCLK   = 0;
    localparam int LB_SL     = 1;
    localparam int LB_SER    = 2;
    localparam int LB_ADDR   = 3;
    localparam int LB_OVF_CH = LB_ADDR + ADDR_W;
    localparam int LB_OVF_G  = LB_OVF_CH + 1;
    localparam int LB_OVF_R  = LB_OVF_G + 1;
    localparam int LB_W      = LB_OVF_R + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2
    } link_state_e;

endpackage

// File: rtl/impulse_count_receiver_link_sync.sv
// rtl/impulse_count_receiver_link_sync.sv - multi-bit link synchronizer with sclk/sl edge detect
module link_sync #(
    parameter int W           = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:2] data_sync,
    output logic         sclk_rise,
    output logic         sl_rise,
    output logic         sl_fall
);

    logic [W-1:0] stage_q [SYNC_STAGES];
    logic [W-1:0] stage_d [SYNC_STAGES];
    logic         sclk_prev_q, sclk_prev_d;
    logic         sl_prev_q, sl_prev_d;
    logic [W-1:0] sync_w;

    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    assign sync_w      = stage_q[SYNC_STAGES-1];
    assign sclk_prev_d = sync_w[0];
    assign sl_prev_d   = sync_w[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            sclk_prev_q <= 1'b0;
            sl_prev_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            sclk_prev_q <= sclk_prev_d;
            sl_prev_q   <= sl_prev_d;
        end
    end

    // Edges compare the synchronized line against its one-cycle-old copy.
    assign sclk_rise = sync_w[0] & ~sclk_prev_q;
    assign sl_rise   = sync_w[1] & ~sl_prev_q;
    assign sl_fall   = ~sync_w[1] & sl_prev_q;
    assign data_sync = sync_w[W-1:2];

endmodule

// File: rtl/impulse_count_receiver.sv
// rtl/impulse_count_receiver.sv - deserializes counter link frames into a per-channel register file
module impulse_count_receiver #(
    parameter int CNT_W       = impulse_link_pkg::CNT_W,
    parameter int N_CH        = impulse_link_pkg::N_CH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_in,
    input  logic             ser_in,
    input  logic             sl_in,
    input  logic [2:0]       addr_in,
    input  logic             ovf_ch_in,
    input  logic             ovf_global_in,
    input  logic             ovf_rtc_in,
    input  logic             clear,
    input  logic [2:0]       rd_addr,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_ovf,
    output logic             frame_done,
    output logic             frame_err,
    output logic             ovf_global,
    output logic             ovf_rtc
);

    localparam int LB_W  = impulse_link_pkg::LB_W;
    localparam int BC_W  = $clog2(CNT_W + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(CNT_W);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(CNT_W + 1);

    logic [LB_W-1:0] link_bus;
    logic [LB_W-1:2] link_s;
    logic            sclk_rise, sl_rise, sl_fall;
    logic            ser_s, ovf_ch_s;
    logic [2:0]      addr_s;

    assign link_bus = {ovf_rtc_in, ovf_global_in, ovf_ch_in, addr_in, ser_in, sl_in, sclk_in};

    link_sync #(
        .W           (LB_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_link_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (link_bus),
        .data_sync (link_s),
        .sclk_rise (sclk_rise),
        .sl_rise   (sl_rise),
        .sl_fall   (sl_fall)
    );

    assign ser_s      = link_s[impulse_link_pkg::LB_SER];
    assign addr_s     = link_s[impulse_link_pkg::LB_ADDR +: 3];
    assign ovf_ch_s   = link_s[impulse_link_pkg::LB_OVF_CH];
    assign ovf_global = link_s[impulse_link_pkg::LB_OVF_G];
    assign ovf_rtc    = link_s[impulse_link_pkg::LB_OVF_R];

    impulse_link_pkg::link_state_e state_q, state_d;
    logic [CNT_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic [2:0]       addr_q, addr_d;
    logic             ovf_ch_q, ovf_ch_d;
    logic [CNT_W-1:0] regs_q [N_CH];
    logic [CNT_W-1:0] regs_d [N_CH];
    logic [N_CH-1:0]  valid_q, valid_d;
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             commit;

    assign commit = (state_q == impulse_link_pkg::ST_CAPTURE) && (bitcnt_q == BC_FULL);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        addr_d   = addr_q;
        ovf_ch_d = ovf_ch_q;
        regs_d   = regs_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        err_d    = err_q;

        unique case (state_q)
            impulse_link_pkg::ST_IDLE: begin
                if (sl_fall) begin
                    state_d  = impulse_link_pkg::ST_SHIFT;
                    shreg_d  = '0;
                    bitcnt_d = '0;
                end
            end
            impulse_link_pkg::ST_SHIFT: begin
                // A bit arriving with the closing sl edge is still taken.
                if (sclk_rise) begin
                    shreg_d = {shreg_q[CNT_W-2:0], ser_s};
                    if (bitcnt_q != BC_SAT) begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                if (sl_rise) begin
                    state_d  = impulse_link_pkg::ST_CAPTURE;
                    addr_d   = addr_s;
                    ovf_ch_d = ovf_ch_s;
                end
            end
            impulse_link_pkg::ST_CAPTURE: begin
                if (commit) begin
                    regs_d[addr_q]  = shreg_q;
                    valid_d[addr_q] = 1'b1;
                    ovf_d[addr_q]   = ovf_ch_q;
                end else begin
                    err_d = 1'b1;
                end
                state_d = impulse_link_pkg::ST_IDLE;
            end
            default: state_d = impulse_link_pkg::ST_IDLE;
        endcase

        // Clear overrides status bits only; a count word being committed still lands.
        if (clear) begin
            valid_d = '0;
            ovf_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= impulse_link_pkg::ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            addr_q   <= '0;
            ovf_ch_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                regs_q[i] <= '0;
            end
            valid_q  <= '0;
            ovf_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            addr_q   <= addr_d;
            ovf_ch_q <= ovf_ch_d;
            regs_q   <= regs_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign rd_data    = regs_q[rd_addr];
    assign rd_valid   = valid_q[rd_addr];
    assign rd_ovf     = ovf_q[rd_addr];
    assign frame_done = commit;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_impulse_count_receiver.sv
// tb/tb_impulse_count_receiver.sv - scoreboard bench for impulse_count_receiver
module tb_impulse_count_receiver;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sclk_in = 1'b0;
    logic             ser_in = 1'b0;
    logic             sl_in = 1'b1;
    logic [2:0]       addr_in = '0;
    logic             ovf_ch_in = 1'b0;
    logic             ovf_global_in = 1'b0;
    logic             ovf_rtc_in = 1'b0;
    logic             clear = 1'b0;
    logic [2:0]       rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid, rd_ovf, frame_done, frame_err, ovf_global, ovf_rtc;

    logic [2:0] main_addr = '0;
    logic [2:0] mon_addr = '0;
    bit         mon_active = 1'b0;
    assign rd_addr = mon_active ? mon_addr : main_addr;

    impulse_count_receiver #(.CNT_W(CNT_W), .N_CH(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sclk_in       (sclk_in),
        .ser_in        (ser_in),
        .sl_in         (sl_in),
        .addr_in       (addr_in),
        .ovf_ch_in     (ovf_ch_in),
        .ovf_global_in (ovf_global_in),
        .ovf_rtc_in    (ovf_rtc_in),
        .clear         (clear),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ovf        (rd_ovf),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .ovf_global    (ovf_global),
        .ovf_rtc       (ovf_rtc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       a;
        logic [CNT_W-1:0] d;
        logic             v;
        logic             o;
    } exp_t;

    exp_t exp_q[$];

    logic [CNT_W-1:0] m_data  [8];
    logic             m_valid [8];
    logic             m_ovf   [8];
    logic             m_err;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_ovf[i]   = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    // A frame closes when sl rises; only exactly CNT_W bits make a valid word.
    task automatic send_frame(input logic [2:0] a, input logic [CNT_W-1:0] v, input int nbits,
                              input logic ovf, input bit clr_cap);
        exp_t e;
        addr_in   = a;
        ovf_ch_in = ovf;
        sl_in     = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = nbits - 1 - i;
            ser_in = (b < CNT_W) ? v[b] : 1'($urandom_range(0, 1));
            tick(2);
            sclk_in = 1'b1;
            tick(2);
            sclk_in = 1'b0;
        end
        tick(2);
        sl_in = 1'b1;
        if (nbits == CNT_W) begin
            m_data[a] = v;
            if (clr_cap) model_clear();
            else begin
                m_valid[a] = 1'b1;
                m_ovf[a]   = ovf;
            end
            e.a = a; e.d = v; e.v = m_valid[a]; e.o = m_ovf[a];
            exp_q.push_back(e);
        end else begin
            if (clr_cap) model_clear();
            else m_err = 1'b1;
        end
        tick(3);
        if (clr_cap) clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(4);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_clear();
        tick(1);
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < 8; i++) begin
            main_addr = 3'(i);
            #1;
            chk($sformatf("%s_data[%0d]", tag, i), 32'(rd_data), 32'(m_data[i]));
            chk($sformatf("%s_valid[%0d]", tag, i), 32'(rd_valid), 32'(m_valid[i]));
            chk($sformatf("%s_ovf[%0d]", tag, i), 32'(rd_ovf), 32'(m_ovf[i]));
        end
        chk($sformatf("%s_err", tag), 32'(frame_err), 32'(m_err));
    endtask

    // Monitor: each commit pulse must match the oldest expected word, read back one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_done", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    mon_addr   = e.a;
                    mon_active = 1'b1;
                    @(posedge clk);
                    #1;
                    chk($sformatf("commit_data@%0d", e.a), 32'(rd_data), 32'(e.d));
                    chk($sformatf("commit_valid@%0d", e.a), 32'(rd_valid), 32'(e.v));
                    chk($sformatf("commit_ovf@%0d", e.a), 32'(rd_ovf), 32'(e.o));
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) m_data[i] = '0;
        model_clear();

        tick(3);
        rst_n = 1'b1;
        tick(3);
        readback("reset");
        chk("reset_frame_done", 32'(frame_done), 32'(0));
        chk("reset_ovf_global", 32'(ovf_global), 32'(0));
        chk("reset_ovf_rtc", 32'(ovf_rtc), 32'(0));

        // Reset in the middle of a frame drops it silently.
        addr_in = 3'd1;
        sl_in   = 1'b0;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            ser_in = 1'b1; tick(2); sclk_in = 1'b1; tick(2); sclk_in = 1'b0;
        end
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        sl_in = 1'b1;
        tick(8);
        readback("midreset");

        send_frame(3'd3, 16'hA5C3, CNT_W, 1'b0, 1'b0);

        for (int ch = 0; ch < 8; ch++) begin
            send_frame(3'(ch), 16'(16'h0001 << ch), CNT_W, (ch == 7), 1'b0);
        end
        readback("sweep");

        pulse_clear();
        send_frame(3'd2, 16'hBEEF, 15, 1'b0, 1'b0);
        readback("short");
        send_frame(3'd2, 16'hBEEF, 17, 1'b0, 1'b0);
        readback("long");
        pulse_clear();
        readback("err_cleared");

        send_frame(3'd5, 16'h1234, CNT_W, 1'b0, 1'b0);
        send_frame(3'd5, 16'hFFFF, CNT_W, 1'b1, 1'b1);
        readback("overwrite_clear");

        ovf_global_in = 1'b1;
        ovf_rtc_in    = 1'b1;
        tick(1);
        chk("ovf_global_early", 32'(ovf_global), 32'(0));
        chk("ovf_rtc_early", 32'(ovf_rtc), 32'(0));
        tick(1);
        chk("ovf_global_rise", 32'(ovf_global), 32'(1));
        chk("ovf_rtc_rise", 32'(ovf_rtc), 32'(1));
        ovf_global_in = 1'b0;
        tick(1);
        chk("ovf_global_hold", 32'(ovf_global), 32'(1));
        tick(1);
        chk("ovf_global_fall", 32'(ovf_global), 32'(0));
        chk("ovf_rtc_stay", 32'(ovf_rtc), 32'(1));

        for (int i = 0; i < 6; i++) begin
            ser_in = 1'($urandom_range(0, 1)); tick(2); sclk_in = 1'b1; tick(2); sclk_in = 1'b0;
        end
        tick(6);
        readback("idle_sclk");

        for (int n = 0; n < 24; n++) begin
            int sel;
            int nb;
            sel = int'($urandom_range(0, 9));
            nb  = (sel == 0) ? 15 : (sel == 1) ? 17 : CNT_W;
            send_frame(3'($urandom_range(0, 7)), 16'($urandom), nb,
                       1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
        readback("random");

        begin
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < 50) begin
                tick(1);
                guard++;
            end
            chk("queue_drain", 32'(exp_q.size()), 32'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/impulse_count_receiver.md
Name: impulse_count_receiver

Overview:
- Host-side deserializer for the serial readout stream produced by the multi-channel impulse counter: serial data, shift/load strobe, serial clock, 3-bit channel address and overflow flags.
- Samples these asynchronous lines into the local clock domain, reassembles each CNT_W-bit count, and stores it per channel in a register file with overflow and valid bits.
- Sits at the FPGA/MCU end of the counter link, feeding a bus-readable register bank.

Parameters:
- CNT_W, 16, bits per channel count word, shifted MSB first.
- N_CH, 8, channel count; address width is 3.
- SYNC_STAGES, 2, flip-flop synchronizer depth on every link input.

Ports:
- clk  input  1  system clock; must be at least 4x the serial clock.
- rst_n  input  1  asynchronous active-low reset.
- sclk_in  input  1  link serial clock; data is valid on its rising edge.
- ser_in  input  1  link serial data.
- sl_in  input  1  link shift/load: 1 = load/idle, 0 = shift.
- addr_in  input  3  channel address of the current frame (a2..a0).
- ovf_ch_in  input  1  channel overflow flag for the current frame.
- ovf_global_in  input  1  global overflow level.
- ovf_rtc_in  input  1  RTC overflow level.
- clear  input  1  synchronous clear of all valid, ovf and err bits.
- rd_addr  input  3  host read address.
- rd_data  output  CNT_W  stored count for rd_addr (combinational mux of registers).
- rd_valid  output  1  valid bit for rd_addr.
- rd_ovf  output  1  latched channel overflow for rd_addr.
- frame_done  output  1  one-cycle pulse when a channel word has been committed.
- frame_err  output  1  sticky framing error.
- ovf_global  output  1  synchronized ovf_global_in.
- ovf_rtc  output  1  synchronized ovf_rtc_in.

Behaviour:
- Reset values: all registers, valid bits, ovf bits, shift register and bit counter are 0. frame_done, frame_err, ovf_global and ovf_rtc are 0. FSM is in IDLE.
- All link inputs pass through a SYNC_STAGES synchronizer. sclk and sl edges are detected on synchronized values against a one-cycle delayed copy.
- FSM IDLE:
  - A falling edge on sl moves to SHIFT and clears the shift register and bit counter.
- FSM SHIFT, on each sclk rising edge:
  - shreg <= {shreg[CNT_W-2:0], ser}.
  - bitcnt increments, saturating at CNT_W+1.
  - A rising edge on sl moves to CAPTURE.
- FSM CAPTURE, one cycle:
  - If bitcnt == CNT_W: regs[addr] <= shreg, valid[addr] <= 1, ovf[addr] <= ovf_ch (sampled at the sl rising edge), frame_done = 1 for this cycle.
  - Otherwise (short or long frame): no register write, frame_err <= 1.
  - Next state is IDLE.
- Address and ovf_ch are captured in the same cycle the sl rising edge is detected.
- Latency: a committed value is visible on rd_data the cycle after frame_done, SYNC_STAGES+2 clk cycles after the sl rise at the pins.
- Simultaneous events:
  - sclk edge in the same cycle as the sl rising edge: the bit is shifted first, then the frame closes.
  - An sclk edge while in IDLE is ignored.
- clear:
  - clear asserted during CAPTURE: clear wins for valid, ovf and err bits, but the count register is still written.
  - clear asserted in SHIFT does not abort the frame in progress.
- Writing a channel whose valid bit is already 1 overwrites the value; there is no lost-data flag.
- Deasserting rst_n mid-frame returns the FSM to IDLE immediately. A partial frame is dropped without setting err.

Decomposition:
- Package impulse_link_pkg holds: CNT_W, N_CH, address width, FSM state encoding (IDLE, SHIFT, CAPTURE).
- Sub-module link_sync: parameterized SYNC_STAGES multi-bit synchronizer with registered edge outputs (rise/fall) for sclk and sl. Instantiated once for the link bus.

Test Plan:
- Reset with rst_n=0 mid-frame (after 5 bits), then release -> FSM in IDLE, all rd_valid 0, frame_err 0, no commit when sl next rises.
- Single frame: addr=3, 16 bits 0xA5C3, ovf_ch=0 -> one frame_done pulse; rd_addr=3 gives rd_data=0xA5C3, rd_valid=1, rd_ovf=0.
- Full sweep of channels 0..7 with values 0x0001<<ch and ovf_ch=1 on ch 7 only -> all 8 valid, correct data, rd_ovf=1 only at addr 7.
- Short frame of 15 bits and long frame of 17 bits to addr 2 -> no write (rd_valid[2]=0), frame_err=1 sticky until clear, after which frame_err=0.
- Overwrite: addr 5 gets 0x1234 then 0xFFFF -> rd_data=0xFFFF; clear pulse asserted in the CAPTURE cycle -> rd_valid[5]=0 and data=0xFFFF.
- ovf_global_in and ovf_rtc_in toggled -> outputs follow after exactly SYNC_STAGES cycles; sclk edges while sl=1 -> no shift and no frame_done.
